// File: rtl/spis_byte_if.sv
// Per-byte control channel between the SPI slave byte engine and the protocol layer above it.
interface spis_byte_if;
  logic       bdir;
  logic [1:0] bmode;
  logic [7:0] tbyte;
  logic [7:0] rbyte;
  logic       bdone;
  logic       abort;

  // Protocol layer: supplies the next byte's setup, consumes results.
  modport master (
    output bdir,
    output bmode,
    output tbyte,
    input  rbyte,
    input  bdone,
    input  abort
  );

  // Byte engine.
  modport slave (
    input  bdir,
    input  bmode,
    input  tbyte,
    output rbyte,
    output bdone,
    output abort
  );
endinterface

// File: rtl/spis_byte.sv
// SPI slave byte engine: oversamples the SPI pads in the clk domain and moves one
// byte per 8/4/2 SPI clocks (1/2/4-bit phases), SPI modes 0 and 3.
module spis_byte (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_n,
  input  logic [1:0]  ckmod,
  spis_byte_if.slave  ctl,
  output logic        csel,
  input  logic        spi_cs_n,
  input  logic        spi_ck,
  input  logic [3:0]  spi_di,
  output logic [3:0]  spi_do,
  output logic [3:0]  spi_oe
);

  localparam int unsigned DW  = 8;
  localparam int unsigned IOW = 4;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOAD = 2'd1,
    S_SHIFT     = 2'd2
  } state_t;

  // Bits moved per SPI edge for a phase mode; mode 3 behaves as 1-bit.
  function automatic logic [CW-1:0] step_of(input logic [1:0] m);
    case (m)
      2'd1:    return CW'(2);
      2'd2:    return CW'(4);
      default: return CW'(1);
    endcase
  endfunction

  // Pin drive pattern for the current top bits of the transmit shifter.
  function automatic logic [IOW-1:0] do_of(input logic [DW-1:0] t, input logic [1:0] m,
                                           input logic d);
    if (!d) return '0;
    case (m)
      2'd1:    return {2'b00, t[7:6]};
      2'd2:    return t[7:4];
      default: return {2'b00, t[7], 1'b0};
    endcase
  endfunction

  // Output enable pattern for a byte's direction and phase mode.
  function automatic logic [IOW-1:0] oe_of(input logic [1:0] m, input logic d);
    if (!d) return '0;
    case (m)
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0010;
    endcase
  endfunction

  // Receive shifter update with the sampled IO pins.
  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] r, input logic [IOW-1:0] d,
                                             input logic [1:0] m);
    case (m)
      2'd1:    return {r[DW-3:0], d[1:0]};
      2'd2:    return {r[DW-5:0], d[3:0]};
      default: return {r[DW-2:0], d[0]};
    endcase
  endfunction

  // Transmit shifter advance by one edge's worth of bits.
  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] t, input logic [1:0] m);
    case (m)
      2'd1:    return {t[DW-3:0], 2'b00};
      2'd2:    return {t[DW-5:0], 4'b0000};
      default: return {t[DW-2:0], 1'b0};
    endcase
  endfunction

  logic [2:0]     cs_sync;
  logic [2:0]     ck_sync;
  logic [IOW-1:0] di_s1;
  logic [IOW-1:0] di_s2;

  logic cs_act;
  logic cs_asrt;
  logic ck_rise;
  logic ck_fall;

  state_t         state, state_n;
  logic           dir_q, dir_n;
  logic [1:0]     mode_q, mode_n;
  logic [DW-1:0]  tsh, tsh_n;
  logic [DW-1:0]  rsh, rsh_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [DW-1:0]  rbyte_n;
  logic           bdone_n;
  logic           abort_n;
  logic           csel_n;
  logic [IOW-1:0] do_n;
  logic [IOW-1:0] oe_n;
  logic           do_load;
  logic [DW-1:0]  rsh_sh;

  // Two-flop synchronisers; the third ck/cs flop feeds edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync <= 3'b111;
      ck_sync <= 3'b000;
      di_s1   <= '0;
      di_s2   <= '0;
    end else if (!clr_n) begin
      cs_sync <= 3'b111;
      ck_sync <= 3'b000;
      di_s1   <= '0;
      di_s2   <= '0;
    end else begin
      cs_sync <= {cs_sync[1:0], spi_cs_n};
      ck_sync <= {ck_sync[1:0], spi_ck};
      di_s1   <= spi_di;
      di_s2   <= di_s1;
    end
  end

  assign cs_act  = ~cs_sync[1];
  assign cs_asrt = ~cs_sync[1] & cs_sync[2];
  assign ck_rise =  ck_sync[1] & ~ck_sync[2];
  assign ck_fall = ~ck_sync[1] &  ck_sync[2];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dir_q     <= 1'b0;
      mode_q    <= 2'd0;
      tsh       <= '0;
      rsh       <= '0;
      cnt       <= '0;
      ctl.rbyte <= '0;
      ctl.bdone <= 1'b0;
      ctl.abort <= 1'b0;
      csel      <= 1'b0;
      spi_do    <= '0;
      spi_oe    <= '0;
    end else begin
      state     <= state_n;
      dir_q     <= dir_n;
      mode_q    <= mode_n;
      tsh       <= tsh_n;
      rsh       <= rsh_n;
      cnt       <= cnt_n;
      ctl.rbyte <= rbyte_n;
      ctl.bdone <= bdone_n;
      ctl.abort <= abort_n;
      csel      <= csel_n;
      spi_do    <= do_n;
      spi_oe    <= oe_n;
    end
  end

  // Next-state and next-output logic; CS release and clear take priority over edges.
  always_comb begin
    state_n = state;
    dir_n   = dir_q;
    mode_n  = mode_q;
    tsh_n   = tsh;
    rsh_n   = rsh;
    cnt_n   = cnt;
    rbyte_n = ctl.rbyte;
    bdone_n = 1'b0;
    abort_n = 1'b0;
    csel_n  = csel;
    do_n    = spi_do;
    oe_n    = spi_oe;
    do_load = 1'b0;
    rsh_sh  = shift_in(rsh, di_s2, mode_q);

    case (state)
      S_IDLE: begin
        if (cs_asrt) begin
          csel_n = 1'b1;
          if (ckmod == 2'b00) begin
            do_load = 1'b1;
            state_n = S_SHIFT;
          end else begin
            state_n = S_WAIT_LOAD;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (ck_fall) begin
          do_load = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ck_rise && cnt != '0) begin
          rsh_n = rsh_sh;
          cnt_n = cnt - step_of(mode_q);
          if (cnt_n == '0) begin
            rbyte_n = rsh_sh;
            bdone_n = 1'b1;
          end
        end else if (ck_fall) begin
          if (cnt == '0) begin
            do_load = 1'b1;
          end else begin
            tsh_n = shift_out(tsh, mode_q);
            do_n  = do_of(tsh_n, mode_q, dir_q);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (do_load) begin
      dir_n  = ctl.bdir;
      mode_n = ctl.bmode;
      tsh_n  = ctl.tbyte;
      cnt_n  = CW'(DW);
      do_n   = do_of(ctl.tbyte, ctl.bmode, ctl.bdir);
      oe_n   = oe_of(ctl.bmode, ctl.bdir);
    end

    if (state != S_IDLE && !cs_act) begin
      abort_n = (state == S_SHIFT) && (cnt != '0) && (cnt != CW'(DW));
      state_n = S_IDLE;
      bdone_n = 1'b0;
      csel_n  = 1'b0;
      oe_n    = '0;
      do_n    = '0;
      cnt_n   = '0;
      rsh_n   = '0;
    end

    if (!clr_n) begin
      state_n = S_IDLE;
      dir_n   = 1'b0;
      mode_n  = 2'd0;
      tsh_n   = '0;
      rsh_n   = '0;
      cnt_n   = '0;
      rbyte_n = '0;
      bdone_n = 1'b0;
      abort_n = 1'b0;
      csel_n  = 1'b0;
      do_n    = '0;
      oe_n    = '0;
    end
  end

endmodule

// File: doc/spis_byte.md
Name: spis_byte

Overview:
- SPI slave byte engine; the target-side counterpart of the SPI master byte engine.
- Oversamples an external SPI bus (spi_cs_n, spi_ck, spi_di) in the clk domain.
- Receives or transmits one byte per 8/4/2 SPI clocks in 1/2/4-bit phase mode, for SPI modes 0 and 3.
- A per-byte control interface (bdir, bmode, tbyte, rbyte, bdone) connects it to a command/protocol layer above.

Parameters:
- None. Input synchroniser depth is fixed at 2 flops.

Ports:
- clk  input  1  system clock; must be >= 8x spi_ck frequency
- rst_n  input  1  asynchronous, active-low reset
- clr_n  input  1  synchronous active-low clear; same effect as rst_n
- ckmod  input  2  2'b00 = mode 0 (idle low); any nonzero = mode 3 (idle high)
- bmode  input  2  0 = 1-bit, 1 = 2-bit, 2 = 4-bit, 3 = treated as 1-bit
- bdir  input  1  0 = receive byte (outputs off), 1 = transmit byte
- tbyte  input  8  byte to transmit
- rbyte  output  8  last completed received byte
- bdone  output  1  one-clk pulse at byte completion
- abort  output  1  one-clk pulse when CS deasserts mid-byte
- csel  output  1  synchronised chip-select active
- spi_cs_n  input  1  chip select, active low, asynchronous
- spi_ck  input  1  SPI clock, asynchronous
- spi_di  input  4  IO pins in
- spi_do  output  4  IO pins out
- spi_oe  output  4  IO output enables

Behaviour:
- Reset (rst_n low or clr_n low): rbyte=0, bdone=0, abort=0, csel=0, spi_do=0, spi_oe=0, state IDLE, count=0.
- Synchronisation: spi_cs_n, spi_ck and spi_di each pass through 2 flops; a 3rd flop on ck/cs provides edge detect.
- Latency: register updates caused by a pad edge occur 3 clk after the first clk edge that sees the new level.
- Bit timing: sampling is on rising spi_ck edges in both modes; shifting is on falling edges.
- Bits per edge: k = 1/2/4 per bmode; edges per byte = 8/k.
- State IDLE: cs inactive. On cs assertion, csel goes to 1.
  - Mode 0: perform a LOAD at the same cycle, then go to SHIFT.
  - Mode 3: go to WAIT_LOAD.
- State WAIT_LOAD: the first falling edge performs a LOAD and moves to SHIFT. Rising edges are ignored.
- LOAD:
  - Latch bdir and bmode for the byte.
  - tsh <= tbyte; count <= 8.
  - If bdir=1: drive top bits immediately. spi_oe = 0010 (1-bit), 0011 (2-bit), 1111 (4-bit).
  - If bdir=0: spi_oe = 0000.
- Output mapping: 1-bit drives do[1]=tsh[7]; 2-bit drives do[1:0]=tsh[7:6]; 4-bit drives do[3:0]=tsh[7:4].
- Rising edge in SHIFT:
  - rsh <= {rsh, di[0]} (1-bit), {rsh, di[1:0]} (2-bit), {rsh, di[3:0]} (4-bit); count -= k.
  - When count reaches 0: rbyte <= new rsh value and bdone=1 in the same cycle.
  - Sampling happens regardless of bdir; rbyte content during a 2/4-bit transmit is don't-care.
- Falling edge in SHIFT:
  - count==0: perform a LOAD for the next byte.
  - Otherwise: tsh <<= k and update spi_do.
- Mode 0 trailing edge: the final falling edge of a transaction performs a harmless LOAD (no handshake is consumed).
- Control timing: the user must present the next byte's bdir/bmode/tbyte within 2 clk after bdone. The 8x clk ratio guarantees this precedes the LOAD.
- CS deassert (any state): csel=0, spi_oe=0000, count=0, state IDLE, partial rsh discarded. If SHIFT with 0<count<8: abort=1 for one clk and no bdone.
- Priority: CS deassert overrides a simultaneous ck edge. Edges seen while cs is inactive are ignored.
- Configuration inputs: ckmod is sampled at cs assertion only. bmode/bdir are sampled only at LOAD.
- Reset or clear mid-byte: immediate return to the reset values. The bus is released (oe=0) at once.

Test Plan:
1. Mode 0, 1-bit, bdir=0; master shifts 0xA5 on di[0] -> exactly one bdone, rbyte=0xA5, spi_oe stays 0000.
2. Mode 0, 1-bit, bdir=1, tbyte=0x3C; master sends 0xFF -> do[1] at 8 rising edges = 0,0,1,1,1,1,0,0; oe=0010 from cs assertion; rbyte=0xFF.
3. Mode 3, 4-bit, bdir=1, tbyte=0x9E -> oe stays 0000 until the first falling edge, then 1111; do[3:0]=9 then E. Then set bdir=0 within 2 clk of bdone; master drives 0x5A -> oe=0000 at next LOAD, rbyte=0x5A.
4. Mode 0, 2-bit receive, back-to-back 0x12, 0x34 in one CS frame -> two bdone pulses 4 SPI clocks apart, rbyte 0x12 then 0x34.
5. CS deasserted after 5 bits of 1-bit receive -> one abort pulse, no bdone, oe=0000. Next frame 0x81 -> rbyte=0x81.
6. Assert clr_n=0 mid-transmit byte -> next clk all outputs at reset values. After release, a new frame transmitting 0xC3 is correct.
